// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory access sizes and FSM states.
package lsu_pkg;

    localparam int MEM_SIZE_WIDTH = 2;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_B = 2'd0;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_H = 2'd1;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_W = 2'd2;

    localparam int LSU_STATE_WIDTH = 2;

    typedef enum logic [LSU_STATE_WIDTH-1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_OUT  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes, load extraction/extension, alignment check.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STRB_WIDTH = XLEN / 8
) (
    input  logic [1:0]                addr,
    input  logic [MEM_SIZE_WIDTH-1:0] size,
    input  logic                      is_unsigned,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [STRB_WIDTH-1:0]     wstrb,
    output logic [XLEN-1:0]           wdata_rep,
    output logic [XLEN-1:0]           load_data,
    output logic                      misaligned
);

    logic [XLEN-1:0] lane;
    logic            sign_b;
    logic            sign_h;

    assign lane   = rdata >> {addr, 3'b000};
    assign sign_b = lane[7] & ~is_unsigned;
    assign sign_h = lane[15] & ~is_unsigned;

    always_comb begin
        wstrb      = '0;
        wdata_rep  = wdata;
        load_data  = '0;
        misaligned = 1'b0;
        unique case (size)
            MEM_SIZE_B: begin
                wstrb     = STRB_WIDTH'(1) << addr;
                wdata_rep = {(XLEN/8){wdata[7:0]}};
                load_data = {{(XLEN-8){sign_b}}, lane[7:0]};
            end
            MEM_SIZE_H: begin
                wstrb      = STRB_WIDTH'(3) << addr;
                wdata_rep  = {(XLEN/16){wdata[15:0]}};
                load_data  = {{(XLEN-16){sign_h}}, lane[15:0]};
                misaligned = addr[0];
            end
            MEM_SIZE_W: begin
                wstrb      = '1;
                load_data  = lane;
                misaligned = (addr != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one instruction in flight, valid/ready memory bus, registered writeback.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STRB_WIDTH = XLEN / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_addr,
    input  logic [XLEN-1:0]           in_wdata,
    input  logic                      in_mem_en,
    input  logic                      in_mem_wen,
    input  logic [MEM_SIZE_WIDTH-1:0] in_mem_size,
    input  logic                      in_mem_unsigned,
    input  logic                      in_gpr_wen,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [XLEN-1:0]           mem_req_addr,
    output logic                      mem_req_wen,
    output logic [XLEN-1:0]           mem_req_wdata,
    output logic [STRB_WIDTH-1:0]     mem_req_wstrb,
    input  logic                      mem_resp_valid,
    input  logic [XLEN-1:0]           mem_resp_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_wdata,
    output logic                      out_gpr_wen,
    output logic                      out_misaligned
);

    lsu_state_t state, state_next;

    logic [XLEN-1:0]           addr_p0;
    logic [XLEN-1:0]           wdata_p0;
    logic [MEM_SIZE_WIDTH-1:0] size_p0;
    logic                      unsigned_p0;
    logic                      wen_p0;
    logic                      gpr_wen_p0;
    logic [XLEN-1:0]           wdata_p1;
    logic                      gpr_wen_p1;
    logic                      misaligned_p1;

    logic                      idle;
    logic [STRB_WIDTH-1:0]     al_wstrb;
    logic [XLEN-1:0]           al_wdata_rep;
    logic [XLEN-1:0]           al_load;
    logic                      al_mis;

    assign idle = (state == LSU_IDLE);

    // In IDLE the aligner judges the incoming op; afterwards it works on the latched one.
    lsu_align #(.XLEN(XLEN), .STRB_WIDTH(STRB_WIDTH)) u_align (
        .addr        (idle ? in_addr[1:0] : addr_p0[1:0]),
        .size        (idle ? in_mem_size : size_p0),
        .is_unsigned (idle ? in_mem_unsigned : unsigned_p0),
        .wdata       (idle ? in_wdata : wdata_p0),
        .rdata       (mem_resp_rdata),
        .wstrb       (al_wstrb),
        .wdata_rep   (al_wdata_rep),
        .load_data   (al_load),
        .misaligned  (al_mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LSU_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LSU_IDLE: if (in_valid) state_next = (in_mem_en && !al_mis) ? LSU_REQ : LSU_OUT;
            LSU_REQ:  if (mem_req_ready) state_next = LSU_RESP;
            LSU_RESP: if (mem_resp_valid) state_next = LSU_OUT;
            LSU_OUT:  if (out_ready) state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        unique case (state)
            LSU_IDLE: in_ready = rst;
            LSU_REQ:  mem_req_valid = 1'b1;
            LSU_OUT:  out_valid = 1'b1;
            default:  ;
        endcase
    end

    // Stage boundary: accepted op fields (_p0) and writeback result (_p1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_p0       <= '0;
            wdata_p0      <= '0;
            size_p0       <= '0;
            unsigned_p0   <= 1'b0;
            wen_p0        <= 1'b0;
            gpr_wen_p0    <= 1'b0;
            wdata_p1      <= '0;
            gpr_wen_p1    <= 1'b0;
            misaligned_p1 <= 1'b0;
        end else begin
            if (idle && in_valid) begin
                addr_p0       <= in_addr;
                wdata_p0      <= in_wdata;
                size_p0       <= in_mem_size;
                unsigned_p0   <= in_mem_unsigned;
                wen_p0        <= in_mem_wen;
                gpr_wen_p0    <= in_gpr_wen;
                misaligned_p1 <= in_mem_en & al_mis;
                wdata_p1      <= in_mem_en ? '0 : in_addr;
                gpr_wen_p1    <= ~in_mem_en & in_gpr_wen;
            end
            if (state == LSU_RESP && mem_resp_valid) begin
                wdata_p1   <= wen_p0 ? '0 : al_load;
                gpr_wen_p1 <= ~wen_p0 & gpr_wen_p0;
            end
        end
    end

    assign mem_req_addr   = {addr_p0[XLEN-1:2], 2'b00};
    assign mem_req_wen    = wen_p0;
    assign mem_req_wdata  = al_wdata_rep;
    assign mem_req_wstrb  = wen_p0 ? al_wstrb : '0;
    assign out_wdata      = wdata_p1;
    assign out_gpr_wen    = gpr_wen_p1;
    assign out_misaligned = misaligned_p1;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized ops checked against a byte-level reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_mem_en = 1'b0;
    logic        in_mem_wen = 1'b0;
    logic [1:0]  in_mem_size = '0;
    logic        in_mem_unsigned = 1'b0;
    logic        in_gpr_wen = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_wdata;
    logic        out_gpr_wen;
    logic        out_misaligned;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_mem_en(in_mem_en), .in_mem_wen(in_mem_wen), .in_mem_size(in_mem_size),
        .in_mem_unsigned(in_mem_unsigned), .in_gpr_wen(in_gpr_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
        .out_gpr_wen(out_gpr_wen), .out_misaligned(out_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        in_valid        = 1'b0;
        in_addr         = $urandom;
        in_wdata        = $urandom;
        in_mem_en       = 1'($urandom);
        in_mem_wen      = 1'($urandom);
        in_mem_size     = 2'($urandom);
        in_mem_unsigned = 1'($urandom);
        in_gpr_wen      = 1'($urandom);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        step();
    endtask

    // Issue one op and walk it through every phase, comparing against the reference model.
    task automatic run_op(input logic [31:0] addr, input logic [31:0] wd, input logic men,
                          input logic wen, input logic [1:0] size, input logic uns, input logic gw,
                          input logic [31:0] rdata, input int req_wait, input int resp_wait,
                          input int out_wait);
        int          nbytes;
        int          off;
        logic        mis;
        logic [31:0] e_addr, e_wdata, e_load, e_out, mask;
        logic [3:0]  e_strb;
        logic        e_gw;

        nbytes = 1 << size;
        off    = int'(addr % 4);
        mis    = men && (size == 2'd3 || (addr % nbytes) != 0);
        e_addr = addr - off;
        for (int i = 0; i < 4; i++) begin
            e_wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
            e_strb[i]         = wen && (i >= off) && (i < off + nbytes);
        end
        e_load = '0;
        if (!mis && men) begin
            mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            e_load = (rdata >> (8 * off)) & mask;
            if (!uns && e_load[8*nbytes-1]) e_load = e_load | ~mask;
        end
        if (!men)           begin e_out = addr;   e_gw = gw;   end
        else if (mis || wen) begin e_out = '0;    e_gw = 1'b0; end
        else                begin e_out = e_load; e_gw = gw;   end

        in_valid = 1'b1; in_addr = addr; in_wdata = wd; in_mem_en = men; in_mem_wen = wen;
        in_mem_size = size; in_mem_unsigned = uns; in_gpr_wen = gw;
        check("accept_in_ready", 32'(in_ready), 32'd1);
        step();
        scramble_inputs();

        if (men && !mis) begin
            for (int k = 0; k <= req_wait; k++) begin
                check("req_valid", 32'(mem_req_valid), 32'd1);
                check("req_addr", mem_req_addr, e_addr);
                check("req_wen", 32'(mem_req_wen), 32'(wen));
                check("req_wstrb", 32'(mem_req_wstrb), 32'(e_strb));
                if (wen) check("req_wdata", mem_req_wdata, e_wdata);
                check("req_in_ready", 32'(in_ready), 32'd0);
                check("req_out_valid", 32'(out_valid), 32'd0);
                mem_req_ready  = (k == req_wait);
                mem_resp_valid = (k < req_wait) ? 1'($urandom) : 1'b0;
                mem_resp_rdata = $urandom;
                step();
            end
            mem_req_ready = 1'b0;
            for (int j = 0; j <= resp_wait; j++) begin
                check("resp_req_valid", 32'(mem_req_valid), 32'd0);
                check("resp_out_valid", 32'(out_valid), 32'd0);
                check("resp_in_ready", 32'(in_ready), 32'd0);
                mem_resp_valid = (j == resp_wait);
                mem_resp_rdata = (j == resp_wait) ? rdata : $urandom;
                step();
            end
            mem_resp_valid = 1'b0;
            mem_resp_rdata = $urandom;
        end else begin
            check("nomem_req_valid", 32'(mem_req_valid), 32'd0);
        end

        for (int m = 0; m <= out_wait; m++) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_wdata", out_wdata, e_out);
            check("out_gpr_wen", 32'(out_gpr_wen), 32'(e_gw));
            check("out_misaligned", 32'(out_misaligned), 32'(mis));
            check("out_in_ready", 32'(in_ready), 32'd0);
            check("out_req_valid", 32'(mem_req_valid), 32'd0);
            out_ready = (m == out_wait);
            step();
        end
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1 rst = 1'b0;
        #5;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_wdata", out_wdata, 32'd0);
        check("rst_out_gpr_wen", 32'(out_gpr_wen), 32'd0);
        check("rst_out_misaligned", 32'(out_misaligned), 32'd0);
        release_reset();
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Directed scenarios
        run_op(32'h8000_0010, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 0, 0, 0);
        run_op(32'h8000_0003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h80FF_1234, 0, 0, 0);
        run_op(32'h8000_0003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'h80FF_1234, 0, 0, 0);
        run_op(32'h8000_0002, 32'h0000_BEEF, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 32'h0, 0, 0, 0);
        run_op(32'h8000_0004, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'hCAFE_F00D, 3, 2, 2);
        run_op(32'h8000_0002, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h0, 0, 0, 0);
        run_op(32'h8000_0001, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 32'h0, 0, 0, 1);
        run_op(32'h8000_0000, 32'h0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 0, 0, 0);
        run_op(32'h8000_0002, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 32'h8001_7FFF, 1, 0, 0);

        // Reset while waiting for a response
        in_valid = 1'b1; in_addr = 32'h8000_0000; in_mem_en = 1'b1; in_mem_wen = 1'b0;
        in_mem_size = 2'd2; in_gpr_wen = 1'b1;
        step();
        scramble_inputs();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rstresp_out_valid", 32'(out_valid), 32'd0);
        check("rstresp_req_valid", 32'(mem_req_valid), 32'd0);
        check("rstresp_in_ready", 32'(in_ready), 32'd0);
        release_reset();
        check("rstresp_rel_in_ready", 32'(in_ready), 32'd1);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stray_resp_out_valid", 32'(out_valid), 32'd0);
            check("stray_resp_in_ready", 32'(in_ready), 32'd1);
        end
        mem_resp_valid = 1'b0;

        // Reset while a misaligned result is being presented
        in_valid = 1'b1; in_addr = 32'h8000_0003; in_mem_en = 1'b1; in_mem_size = 2'd2;
        step();
        scramble_inputs();
        check("mis_before_rst", 32'(out_misaligned), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstout_misaligned", 32'(out_misaligned), 32'd0);
        check("rstout_out_valid", 32'(out_valid), 32'd0);
        release_reset();

        // Randomized ops
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_op(a, $urandom, ($urandom_range(0, 3) != 0), 1'($urandom), sz, 1'($urandom),
                   1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the execute stage (exu) in the NPC core.
- Consumes the exu result (`srd`, used as effective address or pass-through ALU value), store data (`src2`) and memory-op controls.
- Performs at most one data-memory transaction over a valid/ready request/response bus, aligns and extends load data, and presents the writeback value and GPR write enable to the writeback/GPR file.
- Non-memory instructions pass through with one cycle of registered latency.

Parameters:
- XLEN, 32, datapath and address width (matches `ISA_WIDTH`).
- STRB_WIDTH, XLEN/8, byte strobe width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  exu result valid.
- in_ready  out  1  lsu can accept an instruction.
- in_addr  in  XLEN  exu result: effective address, or ALU value for non-memory ops.
- in_wdata  in  XLEN  store data (rs2 value).
- in_mem_en  in  1  instruction accesses memory.
- in_mem_wen  in  1  1=store, 0=load (valid only when in_mem_en).
- in_mem_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- in_mem_unsigned  in  1  zero-extend load (lbu/lhu).
- in_gpr_wen  in  1  instruction writes rd.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  word-aligned address (low 2 bits forced 0).
- mem_req_wen  out  1  write request.
- mem_req_wdata  out  XLEN  lane-replicated store data.
- mem_req_wstrb  out  STRB_WIDTH  byte strobes (0 for loads).
- mem_resp_valid  in  1  response/ack valid (one per request, loads and stores).
- mem_resp_rdata  in  XLEN  raw word read data.
- out_valid  out  1  writeback data valid.
- out_ready  in  1  writeback stage accepts.
- out_wdata  out  XLEN  value to write to rd.
- out_gpr_wen  out  1  write enable for rd.
- out_misaligned  out  1  access was misaligned/illegal; no memory access performed.

Behaviour:
- FSM states: IDLE, REQ, RESP, OUT. Registered state, binary encoded.
- Reset (rst low, any state, any time): state=IDLE and all registered fields cleared. While rst is low, in_ready=0, mem_req_valid=0, out_valid=0, out_wdata=0, out_gpr_wen=0, out_misaligned=0.
- After reset release: in_ready=1. Any pending memory transaction is abandoned. A stray mem_resp_valid seen in IDLE is ignored.
- IDLE:
  - in_ready=1.
  - On in_valid, latch all in_* fields.
  - Non-memory op: out_wdata<=in_addr, out_gpr_wen<=in_gpr_wen, go to OUT.
  - Memory op, aligned: go to REQ.
  - Memory op, misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 3): out_misaligned<=1, out_gpr_wen<=0, out_wdata<=0, go to OUT. No bus activity.
- REQ:
  - mem_req_valid=1; addr/wen/wdata/wstrb held stable until handshake.
  - On mem_req_ready, go to RESP.
  - mem_resp_valid in REQ is ignored; memory responds no earlier than the cycle after acceptance.
- RESP:
  - Wait any number of cycles for mem_resp_valid, then go to OUT.
  - Loads: lane = rdata >> (addr[1:0]*8); byte/half sign- or zero-extended per in_mem_unsigned; out_wdata registered, out_gpr_wen=in_gpr_wen.
  - Stores: out_wdata=0, out_gpr_wen=0.
- OUT:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_ready, go to IDLE (out_valid drops next cycle).
- Store lanes:
  - byte: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - half: wdata={2{h}}, wstrb=4'b0011<<addr[1:0].
  - word: wdata unchanged, wstrb=4'b1111.
- Throughput: one instruction in flight. in_ready=0 outside IDLE.
- Latency, accept to out_valid: non-memory or misaligned = 1 cycle. Zero-wait memory (ready=1, resp next cycle) = 3 cycles.

Decomposition:
- Shared `config.v` gains: `MEM_SIZE_B/H/W` codes and `MEM_SIZE_WIDTH`, LSU state codes (`LSU_IDLE`..`LSU_OUT`, `LSU_STATE_WIDTH`). `XLEN` reuses `ISA_WIDTH`.
- One combinational sub-module, lsu_align:
  - inputs: addr[1:0], size, unsigned, wdata, rdata.
  - outputs: wstrb, replicated wdata, extended load data, misaligned flag.
- lsu holds only the FSM and registers.

Test Plan:
- Non-memory pass-through: in_addr=0x80000010, mem_en=0, gpr_wen=1 -> next cycle out_valid=1, out_wdata=0x80000010, out_gpr_wen=1, mem_req_valid never asserted.
- lb sign: addr=0x80000003, size=0, unsigned=0, rdata=0x80FF1234 -> mem_req_addr=0x80000000, out_wdata=0xFFFFFF80; same with unsigned=1 -> 0x00000080.
- sh at addr=0x80000002, wdata=0x0000BEEF -> mem_req_wdata=0xBEEFBEEF, wstrb=4'b1100, wen=1; after ack out_gpr_wen=0.
- Backpressure: mem_req_ready low 3 cycles, then resp 2 cycles later, then out_ready low 2 cycles -> request fields and out_wdata stable throughout; in_ready=0 until OUT handshake completes.
- Misaligned lw at 0x80000002 -> out_misaligned=1, out_gpr_wen=0 after 1 cycle, no mem_req_valid.
- Reset asserted in RESP -> immediately out_valid=0, mem_req_valid=0; after release in_ready=1; a late mem_resp_valid=1 produces no out_valid.
